// File: rtl/opacc_kstep.sv
// opacc_kstep: multi-tile outer-product accumulator.
// NREGS tiles of ML x VL elements. Commands: ZERO, LOAD (row-wise via ci),
// MAC (up to KL a/b beats, c[i][j] += a[i]*b[j]), STORE (row-wise via co).
// Optional build macro OPACC_SAT_EN: signed saturating accumulate with a
// sticky sat_flag; when undefined, arithmetic wraps and sat_flag is 0.
module opacc_kstep #(
    parameter int unsigned NREGS = 2,
    parameter int unsigned VL    = 4,
    parameter int unsigned ML    = 4,
    parameter int unsigned KL    = 4,
    parameter int unsigned XLEN  = 64,
    localparam int unsigned TW   = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int unsigned LW   = $clog2(KL + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [TW-1:0]      cmd_tile,
    input  logic [LW-1:0]      cmd_len,
    input  logic               ab_valid,
    output logic               ab_ready,
    input  logic [ML*XLEN-1:0] ai,
    input  logic [VL*XLEN-1:0] bi,
    input  logic               ci_valid,
    output logic               ci_ready,
    input  logic [VL*XLEN-1:0] ci,
    output logic               co_valid,
    input  logic               co_ready,
    output logic [VL*XLEN-1:0] co,
    output logic               busy,
    output logic               sat_flag
);

    localparam int unsigned CMAX = (ML > KL) ? ML : KL;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned RW   = (ML > 1) ? $clog2(ML) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ML - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_STORE
    } state_t;

    typedef enum logic [1:0] {
        OP_ZERO  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_MAC   = 2'd2,
        OP_STORE = 2'd3
    } op_t;

    state_t state, state_nx;

    logic [XLEN-1:0] tile    [NREGS][ML][VL];
    logic [XLEN-1:0] mac_res [ML][VL];

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [RW-1:0] row;
    logic [RW-1:0] row_nx;
    logic [LW-1:0] len_q;
    logic [TW-1:0] tsel;
    logic          tile_ok;
    logic          cmd_acc;
    logic          ci_hs;
    logic          ab_hs;
    logic          co_hs;
    logic          last_row;
    logic          last_step;

    // Out-of-range tile indices only exist when NREGS is not a power of two
    if ((1 << TW) == NREGS) begin : g_tile_pow2
        assign tile_ok = 1'b1;
    end else begin : g_tile_chk
        assign tile_ok = ({1'b0, cmd_tile} < (TW + 1)'(NREGS));
    end

    assign cnt_nx    = cnt + 1'b1;
    assign row       = cnt[RW-1:0];
    assign row_nx    = cnt_nx[RW-1:0];
    assign last_row  = (cnt == LAST_ROW);
    assign last_step = (cnt_nx == CW'(len_q));
    assign cmd_acc   = cmd_valid && cmd_ready && tile_ok;
    assign ci_hs     = ci_valid && ci_ready;
    assign ab_hs     = ab_valid && ab_ready;
    assign co_hs     = co_valid && co_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    case (op_t'(cmd_op))
                        OP_LOAD:  state_nx = S_LOAD;
                        OP_MAC:   state_nx = (cmd_len != '0) ? S_MAC : S_IDLE;
                        OP_STORE: state_nx = S_STORE;
                        default:  state_nx = S_IDLE;
                    endcase
                end
            end
            S_LOAD:  if (ci_hs && last_row)  state_nx = S_IDLE;
            S_MAC:   if (ab_hs && last_step) state_nx = S_IDLE;
            S_STORE: if (co_hs && last_row)  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        cmd_ready = (state == S_IDLE) && reset;
        ci_ready  = (state == S_LOAD);
        ab_ready  = (state == S_MAC);
        co_valid  = (state == S_STORE);
        busy      = (state != S_IDLE);
    end

`ifdef OPACC_SAT_EN
    localparam logic signed [2*XLEN:0] SMAX =
        $signed({{(XLEN + 2){1'b0}}, {(XLEN - 1){1'b1}}});
    localparam logic signed [2*XLEN:0] SMIN =
        $signed({{(XLEN + 2){1'b1}}, {(XLEN - 1){1'b0}}});
    logic sat_any;
    logic sat_q;
`endif

    // Per-element accumulate result for the selected tile
    always_comb begin
        logic [XLEN-1:0] a_e;
        logic [XLEN-1:0] b_e;
        logic [XLEN-1:0] acc;
`ifdef OPACC_SAT_EN
        logic signed [2*XLEN-1:0] prod;
        logic signed [2*XLEN:0]   sum;
        prod    = '0;
        sum     = '0;
        sat_any = 1'b0;
`endif
        a_e = '0;
        b_e = '0;
        acc = '0;
        for (int unsigned i = 0; i < ML; i++) begin
            for (int unsigned j = 0; j < VL; j++) begin
                a_e = ai[i*XLEN +: XLEN];
                b_e = bi[j*XLEN +: XLEN];
                acc = tile[tsel][i][j];
`ifdef OPACC_SAT_EN
                prod = (2*XLEN)'($signed(a_e)) * (2*XLEN)'($signed(b_e));
                sum  = (2*XLEN + 1)'(prod) + (2*XLEN + 1)'($signed(acc));
                if (sum > SMAX) begin
                    mac_res[i][j] = SMAX[XLEN-1:0];
                    sat_any       = 1'b1;
                end else if (sum < SMIN) begin
                    mac_res[i][j] = SMIN[XLEN-1:0];
                    sat_any       = 1'b1;
                end else begin
                    mac_res[i][j] = sum[XLEN-1:0];
                end
`else
                mac_res[i][j] = acc + a_e * b_e;
`endif
            end
        end
    end

    // Datapath: counter, latched command fields, tile storage and co row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            len_q <= '0;
            tsel  <= '0;
            co    <= '0;
            for (int unsigned t = 0; t < NREGS; t++)
                for (int unsigned i = 0; i < ML; i++)
                    for (int unsigned j = 0; j < VL; j++)
                        tile[t][i][j] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_acc) begin
                        cnt  <= '0;
                        tsel <= cmd_tile;
                        case (op_t'(cmd_op))
                            OP_ZERO: begin
                                for (int unsigned i = 0; i < ML; i++)
                                    for (int unsigned j = 0; j < VL; j++)
                                        tile[cmd_tile][i][j] <= '0;
                            end
                            OP_MAC: len_q <= cmd_len;
                            OP_STORE: begin
                                for (int unsigned j = 0; j < VL; j++)
                                    co[j*XLEN +: XLEN] <= tile[cmd_tile][0][j];
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (ci_hs) begin
                        cnt <= cnt_nx;
                        for (int unsigned j = 0; j < VL; j++)
                            tile[tsel][row][j] <= ci[j*XLEN +: XLEN];
                    end
                end
                S_MAC: begin
                    if (ab_hs) begin
                        cnt <= cnt_nx;
                        for (int unsigned i = 0; i < ML; i++)
                            for (int unsigned j = 0; j < VL; j++)
                                tile[tsel][i][j] <= mac_res[i][j];
                    end
                end
                S_STORE: begin
                    // co is preloaded one row ahead so it is valid on the
                    // cycle after each handshake without a read bubble
                    if (co_hs) begin
                        cnt <= cnt_nx;
                        if (!last_row) begin
                            for (int unsigned j = 0; j < VL; j++)
                                co[j*XLEN +: XLEN] <= tile[tsel][row_nx][j];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OPACC_SAT_EN
    // Sticky saturation flag; a ZERO on any tile clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else if (state == S_IDLE && cmd_acc && op_t'(cmd_op) == OP_ZERO) begin
            sat_q <= 1'b0;
        end else if (ab_hs && sat_any) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_opacc_kstep.sv
// Directed self-checking bench for opacc_kstep (NREGS=2, ML=VL=2, KL=4, XLEN=8).
// Rows are packed element 0 in the low byte: row {x,y} -> {8'dy, 8'dx}.
module tb_opacc_kstep;

    localparam int unsigned NREGS = 2;
    localparam int unsigned VL    = 2;
    localparam int unsigned ML    = 2;
    localparam int unsigned KL    = 4;
    localparam int unsigned XLEN  = 8;

    localparam logic [1:0] OP_ZERO  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_MAC   = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

`ifdef OPACC_SAT_EN
    localparam logic [15:0] EXP_K_ROW0_A = 16'h007F; // {127,0}
    localparam logic [15:0] EXP_K_ROW0_B = 16'h4B7F; // {127,75}
    localparam logic        EXP_SAT      = 1'b1;
`else
    localparam logic [15:0] EXP_K_ROW0_A = 16'h0000; // 256 wraps to 0
    localparam logic [15:0] EXP_K_ROW0_B = 16'h4BFF; // {255,75}
    localparam logic        EXP_SAT      = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [0:0]        cmd_tile;
    logic [2:0]        cmd_len;
    logic              ab_valid;
    logic              ab_ready;
    logic [ML*XLEN-1:0] ai;
    logic [VL*XLEN-1:0] bi;
    logic              ci_valid;
    logic              ci_ready;
    logic [VL*XLEN-1:0] ci;
    logic              co_valid;
    logic              co_ready;
    logic [VL*XLEN-1:0] co;
    logic              busy;
    logic              sat_flag;

    int checks   = 0;
    int failures = 0;

    opacc_kstep #(
        .NREGS(NREGS),
        .VL   (VL),
        .ML   (ML),
        .KL   (KL),
        .XLEN (XLEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_tile (cmd_tile),
        .cmd_len  (cmd_len),
        .ab_valid (ab_valid),
        .ab_ready (ab_ready),
        .ai       (ai),
        .bi       (bi),
        .ci_valid (ci_valid),
        .ci_ready (ci_ready),
        .ci       (ci),
        .co_valid (co_valid),
        .co_ready (co_ready),
        .co       (co),
        .busy     (busy),
        .sat_flag (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic tile, input logic [2:0] len);
        int n;
        cmd_op    = op;
        cmd_tile  = tile;
        cmd_len   = len;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic ci_beat(input logic [15:0] row);
        int n;
        ci       = row;
        ci_valid = 1'b1;
        n = 0;
        while (!ci_ready && n < 20) begin
            tick();
            n++;
        end
        check("ci_ready", ci_ready, 1);
        tick();
        ci_valid = 1'b0;
    endtask

    task automatic ab_beat(input logic [15:0] a, input logic [15:0] b);
        int n;
        ai       = a;
        bi       = b;
        ab_valid = 1'b1;
        n = 0;
        while (!ab_ready && n < 20) begin
            tick();
            n++;
        end
        check("ab_ready", ab_ready, 1);
        tick();
        ab_valid = 1'b0;
    endtask

    task automatic store_chk(input string tag, input logic tile,
                             input logic [15:0] r0, input logic [15:0] r1);
        co_ready = 1'b1;
        issue(OP_STORE, tile, 3'd0);
        check({tag, "_v0"}, co_valid, 1);
        check({tag, "_r0"}, co, r0);
        tick();
        check({tag, "_v1"}, co_valid, 1);
        check({tag, "_r1"}, co, r1);
        tick();
        check({tag, "_vend"}, co_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_tile  = '0;
        cmd_len   = '0;
        ab_valid  = 1'b0;
        ai        = '0;
        bi        = '0;
        ci_valid  = 1'b0;
        ci        = '0;
        co_ready  = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_co_valid", co_valid, 0);
        check("rst_ab_ready", ab_ready, 0);
        check("rst_ci_ready", ci_ready, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_co", co, 0);
        reset = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // Strobes outside their states are ignored
        ab_valid = 1'b1;
        ci_valid = 1'b1;
        tick();
        check("idle_ab_ready", ab_ready, 0);
        check("idle_ci_ready", ci_ready, 0);
        check("idle_busy", busy, 0);
        ab_valid = 1'b0;
        ci_valid = 1'b0;

        // LOAD tile0 {1,2},{3,4} then STORE it back
        issue(OP_LOAD, 1'b0, 3'd0);
        check("load_busy", busy, 1);
        check("load_cmd_ready", cmd_ready, 0);
        ci_beat(16'h0201);
        ci_beat(16'h0403);
        check("load_done", busy, 0);
        store_chk("st0", 1'b0, 16'h0201, 16'h0403);

        // STORE tile0 with co backpressure: co holds row 0
        co_ready = 1'b0;
        issue(OP_STORE, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            check("bp_co", co, 16'h0201);
            check("bp_valid", co_valid, 1);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        co_ready = 1'b1;
        check("bp_co_rel", co, 16'h0201);
        tick();
        check("bp_co_r1", co, 16'h0403);
        tick();
        check("bp_end", co_valid, 0);

        // ZERO tile1; MAC len=2 with a stall gap between beats
        issue(OP_ZERO, 1'b1, 3'd0);
        check("zero_busy", busy, 0);
        issue(OP_MAC, 1'b1, 3'd2);
        ab_beat(16'h0201, 16'h0403);
        check("gap_ab_ready", ab_ready, 1);
        check("gap_busy", busy, 1);
        tick();
        ab_beat(16'h0605, 16'h0807);
        check("mac_done", busy, 0);
        // row0 = {1*3+5*7, 1*4+5*8} = {38,44}; row1 = {2*3+6*7, 2*4+6*8} = {48,56}
        store_chk("st1", 1'b1, 16'h2C26, 16'h3830);

        // MAC len=0 is a no-op
        issue(OP_MAC, 1'b1, 3'd0);
        check("len0_busy", busy, 0);
        check("len0_cmd_ready", cmd_ready, 1);
        store_chk("st1_len0", 1'b1, 16'h2C26, 16'h3830);

        // Wrap / saturation on tile0
        issue(OP_ZERO, 1'b0, 3'd0);
        issue(OP_MAC, 1'b0, 3'd1);
        ab_beat(16'h0010, 16'h0010);
        check("k_sat_a", sat_flag, EXP_SAT);
        store_chk("stk_a", 1'b0, EXP_K_ROW0_A, 16'h0000);
        // a={15,3}, b={17,5}: c00 += 255, c01 = 75, c10 = 51, c11 = 15
        issue(OP_MAC, 1'b0, 3'd1);
        ab_beat(16'h030F, 16'h0511);
        check("k_sat_b", sat_flag, EXP_SAT);
        store_chk("stk_b", 1'b0, EXP_K_ROW0_B, 16'h0F33);
        store_chk("st1_iso", 1'b1, 16'h2C26, 16'h3830);

        // ZERO on another tile clears the sticky flag
        issue(OP_ZERO, 1'b1, 3'd0);
        check("zero_sat_clr", sat_flag, 0);

        // Reset mid-MAC aborts and clears all tiles
        issue(OP_LOAD, 1'b1, 3'd0);
        ci_beat(16'h0A09);
        ci_beat(16'h0C0B);
        issue(OP_MAC, 1'b1, 3'd3);
        ab_beat(16'h0101, 16'h0101);
        ab_beat(16'h0101, 16'h0101);
        check("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ab_ready", ab_ready, 0);
        tick();
        check("arst_busy2", busy, 0);
        reset = 1'b1;
        #1;
        check("arst_cmd_ready", cmd_ready, 1);
        store_chk("arst_t0", 1'b0, 16'h0000, 16'h0000);
        store_chk("arst_t1", 1'b1, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
